// File: rtl/speed_scan_scheduler.sv
// speed_scan_scheduler
// Round-robin speed measurement over NCH motor pulse inputs. One synchroniser
// and one rising-edge counter are shared: each enabled channel in turn is
// selected, allowed to settle, gated for WIN_CYCLES clocks, then the edge
// count is published and stored in a per-channel speed table.

module speed_scan_scheduler #(
    parameter int NCH           = 4,
    parameter int CHW           = 2,
    parameter int WIN_CYCLES    = 40000000,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [NCH-1:0] ch_mask,
    input  logic [NCH-1:0] pulse_in,
    input  logic [CHW-1:0] rd_ch,
    output logic [7:0]     rd_speed,
    output logic [CHW-1:0] cur_ch,
    output logic           win_active,
    output logic           speed_valid,
    output logic [7:0]     speed_out,
    output logic [CHW-1:0] speed_ch,
    output logic           ovf,
    output logic           busy
);

    // Counter widths hold the terminal value (one past the last index).
    localparam int WCW = $clog2(WIN_CYCLES + 1);
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [WCW-1:0] WIN_LAST    = WCW'(WIN_CYCLES - 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [CHW-1:0] CH_RESET    = CHW'(NCH - 1);
    localparam logic [8:0]     CNT_SAT     = 9'd256;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SELECT  = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_PUBLISH = 2'd3;

    // Next channel: lowest set mask bit above cur, else lowest set bit overall
    // (which is cur itself when cur is the only set bit).
    function automatic logic [CHW-1:0] next_channel(
        input logic [CHW-1:0] cur,
        input logic [NCH-1:0] mask
    );
        logic [CHW-1:0] above_v;
        logic [CHW-1:0] first_v;
        logic           above_hit_v;
        above_v     = cur;
        first_v     = cur;
        above_hit_v = 1'b0;
        // Scan downwards so the last hit recorded is the lowest index.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_v = CHW'(i);
                if (i > int'(cur)) begin
                    above_v     = CHW'(i);
                    above_hit_v = 1'b1;
                end else begin
                    above_v     = above_v;
                end
            end else begin
                first_v = first_v;
            end
        end
        return above_hit_v ? above_v : first_v;
    endfunction

    logic [1:0]     state_r;
    logic [1:0]     state_nxt_s;
    logic [CHW-1:0] cur_ch_r;
    logic [SCW-1:0] settle_cnt_r;
    logic [WCW-1:0] win_cnt_r;
    logic [8:0]     edge_cnt_r;
    logic [8:0]     edge_cnt_nxt_s;
    logic           sync1_r;
    logic           sync2_r;
    logic           prev_r;
    logic           edge_s;
    logic           pick_ok_s;
    logic [CHW-1:0] next_ch_s;
    logic           publish_s;
    logic [7:0]     table_r [NCH];
    logic [7:0]     rd_speed_s;

    logic           speed_valid_r;
    logic [7:0]     speed_out_r;
    logic [CHW-1:0] speed_ch_r;
    logic           ovf_r;
    logic           win_active_r;
    logic           busy_r;

    assign pick_ok_s = enable & (|ch_mask);
    assign next_ch_s = next_channel(cur_ch_r, ch_mask);
    assign edge_s    = sync2_r & ~prev_r;
    assign publish_s = (state_r == ST_MEASURE) && (state_nxt_s == ST_PUBLISH);

    // Edge count including this cycle's edge; sticks at 256 instead of wrapping.
    always_comb begin
        edge_cnt_nxt_s = edge_cnt_r;
        if ((state_r == ST_MEASURE) && edge_s && (edge_cnt_r != CNT_SAT)) begin
            edge_cnt_nxt_s = edge_cnt_r + 9'd1;
        end else begin
            edge_cnt_nxt_s = edge_cnt_r;
        end
    end

    // Scan sequencer next-state; dropping enable aborts SELECT/MEASURE at once.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_ok_s) begin
                    state_nxt_s = ST_SELECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (settle_cnt_r == SETTLE_LAST) begin
                    state_nxt_s = ST_MEASURE;
                end else begin
                    state_nxt_s = ST_SELECT;
                end
            end
            ST_MEASURE: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (win_cnt_r == WIN_LAST) begin
                    state_nxt_s = ST_PUBLISH;
                end else begin
                    state_nxt_s = ST_MEASURE;
                end
            end
            ST_PUBLISH: begin
                if (pick_ok_s) begin
                    state_nxt_s = ST_SELECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and channel pointer; the pointer moves only at a pick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cur_ch_r <= CH_RESET;
        end else begin
            state_r <= state_nxt_s;
            if (((state_r == ST_IDLE) || (state_r == ST_PUBLISH)) && pick_ok_s) begin
                cur_ch_r <= next_ch_s;
            end
        end
    end

    // Settle/window timers run only inside their phase; edge count clears in SELECT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle_cnt_r <= '0;
            win_cnt_r    <= '0;
            edge_cnt_r   <= 9'd0;
        end else begin
            if (state_r == ST_SELECT) begin
                settle_cnt_r <= settle_cnt_r + SCW'(1);
            end else begin
                settle_cnt_r <= '0;
            end
            if (state_r == ST_MEASURE) begin
                win_cnt_r <= win_cnt_r + WCW'(1);
            end else begin
                win_cnt_r <= '0;
            end
            if (state_r == ST_SELECT) begin
                edge_cnt_r <= 9'd0;
            end else if (state_r == ST_MEASURE) begin
                edge_cnt_r <= edge_cnt_nxt_s;
            end
        end
    end

    // Two-flop synchroniser on the selected pin; prev is primed on the last
    // settle cycle so a level already high at select time is not an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= pulse_in[cur_ch_r];
            sync2_r <= sync1_r;
            if (((state_r == ST_SELECT) && (settle_cnt_r == SETTLE_LAST)) ||
                (state_r == ST_MEASURE)) begin
                prev_r <= sync2_r;
            end
        end
    end

    // Result registers load on the edge into PUBLISH and hold until the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speed_valid_r <= 1'b0;
            speed_out_r   <= 8'd0;
            speed_ch_r    <= '0;
            ovf_r         <= 1'b0;
        end else begin
            speed_valid_r <= publish_s;
            if (publish_s) begin
                speed_out_r <= (edge_cnt_nxt_s > 9'd255) ? 8'd255 : edge_cnt_nxt_s[7:0];
                ovf_r       <= (edge_cnt_nxt_s > 9'd255);
                speed_ch_r  <= cur_ch_r;
            end
        end
    end

    // Status flags registered from the next state so they align with the phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_active_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            win_active_r <= (state_nxt_s == ST_MEASURE);
            busy_r       <= (state_nxt_s != ST_IDLE);
        end
    end

    // Speed table is written at the end of PUBLISH, so a same-cycle read sees the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                table_r[i] <= 8'd0;
            end
        end else begin
            if (state_r == ST_PUBLISH) begin
                table_r[cur_ch_r] <= speed_out_r;
            end
        end
    end

    // Combinational table read; out-of-range indices read as zero.
    always_comb begin
        rd_speed_s = 8'd0;
        if (int'(rd_ch) < NCH) begin
            rd_speed_s = table_r[rd_ch];
        end else begin
            rd_speed_s = 8'd0;
        end
    end

    assign rd_speed    = rd_speed_s;
    assign cur_ch      = cur_ch_r;
    assign win_active  = win_active_r;
    assign speed_valid = speed_valid_r;
    assign speed_out   = speed_out_r;
    assign speed_ch    = speed_ch_r;
    assign ovf         = ovf_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_speed_scan_scheduler.sv
// Testbench for speed_scan_scheduler: randomized pulse trains, reference model
// computes each window's expected count from the recorded pin history.

module tb_speed_scan_scheduler;

    localparam int NCH    = 4;
    localparam int CHW    = 2;
    localparam int WIN    = 1000;
    localparam int SET    = 4;
    localparam int PERIOD = SET + WIN + 1;
    localparam int HMAX   = 65536;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           enable = 1'b0;
    logic [NCH-1:0] ch_mask = '0;
    logic [NCH-1:0] pulse_in = '0;
    logic [CHW-1:0] rd_ch = '0;
    logic [7:0]     rd_speed;
    logic [CHW-1:0] cur_ch;
    logic           win_active;
    logic           speed_valid;
    logic [7:0]     speed_out;
    logic [CHW-1:0] speed_ch;
    logic           ovf;
    logic           busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nvalid = 0;
    logic [NCH-1:0] hist [0:HMAX-1];

    // pulse generator settings per channel: per=0 means constant level hi
    int per [NCH];
    int hi  [NCH];
    int ph  [NCH];
    bit noise [NCH];

    // reference model state
    int             m_cur;
    logic [NCH-1:0] m_mask;
    int             m_table [NCH];
    int             next_s;

    speed_scan_scheduler #(
        .NCH(NCH), .CHW(CHW), .WIN_CYCLES(WIN), .SETTLE_CYCLES(SET)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
        .pulse_in(pulse_in), .rd_ch(rd_ch), .rd_speed(rd_speed),
        .cur_ch(cur_ch), .win_active(win_active), .speed_valid(speed_valid),
        .speed_out(speed_out), .speed_ch(speed_ch), .ovf(ovf), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    // record pin levels as seen at each rising edge
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (cyc < HMAX) hist[cyc] = pulse_in;
    end

    // pulse pins change on the falling edge
    initial forever begin
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            if (noise[c]) pulse_in[c] = 1'($urandom_range(0, 1));
            else if (per[c] == 0) pulse_in[c] = (hi[c] != 0);
            else pulse_in[c] = (((cyc + 1 + ph[c]) % per[c]) < hi[c]);
        end
    end

    initial forever begin
        @(negedge clk);
        if (speed_valid) nvalid = nvalid + 1;
    end

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int rr_next(input int cur, input logic [NCH-1:0] mask);
        for (int d = 1; d <= NCH; d++) begin
            int c;
            c = (cur + d) % NCH;
            if (mask[c]) return c;
        end
        return cur;
    endfunction

    // Rising edges on the channel as the window sees them: the 2-flop
    // synchroniser delays the pin, and the window spans WIN transitions.
    function automatic int model_edges(input int s, input int ch);
        int c;
        c = 0;
        for (int k = s + SET - 1; k <= s + SET + WIN - 2; k++)
            if (hist[k][ch] && !hist[k-1][ch]) c++;
        return c;
    endfunction

    task automatic set_clock(input int c, input int p, input int h);
        noise[c] = 1'b0; per[c] = p; hi[c] = h; ph[c] = $urandom_range(0, p - 1);
    endtask

    task automatic set_level(input int c, input int lvl);
        noise[c] = 1'b0; per[c] = 0; hi[c] = lvl;
    endtask

    task automatic start_scan(input logic [NCH-1:0] mask);
        ch_mask = mask; m_mask = mask; enable = 1'b1;
        next_s = cyc + 1;
    endtask

    task automatic scan_windows(input int n, input bit chg, input logic [NCH-1:0] new_mask);
        for (int j = 0; j < n; j++) begin
            int s, ch, cnt, exp_spd;
            bit exp_ovf;
            s = next_s;
            ch = rr_next(m_cur, m_mask);
            m_cur = ch;
            if (chg && j == 0) begin
                wait_until(s + SET + 100);
                ch_mask = new_mask; m_mask = new_mask;
            end
            wait_until(s + SET + WIN - 1);
            rd_ch = CHW'(ch);
            checks++;
            if (win_active !== 1'b1 || speed_valid !== 1'b0 || cur_ch !== CHW'(ch)) begin
                failures++;
                $display("FAIL last_measure: win_active=%b speed_valid=%b cur_ch=%0d, required 1 0 %0d",
                         win_active, speed_valid, cur_ch, ch);
            end
            wait_until(s + SET + WIN);
            cnt = model_edges(s, ch);
            exp_spd = (cnt > 255) ? 255 : cnt;
            exp_ovf = (cnt > 255);
            checks++;
            if (speed_valid !== 1'b1 || speed_out !== 8'(exp_spd) || ovf !== exp_ovf ||
                speed_ch !== CHW'(ch) || win_active !== 1'b0) begin
                failures++;
                $display("FAIL publish: valid=%b speed=%0d ovf=%b ch=%0d win=%b, required 1 %0d %b %0d 0",
                         speed_valid, speed_out, ovf, speed_ch, win_active, exp_spd, exp_ovf, ch);
            end
            checks++;
            if (rd_speed !== 8'(m_table[ch])) begin
                failures++;
                $display("FAIL rd_old ch=%0d: rd_speed=%0d, required %0d", ch, rd_speed, m_table[ch]);
            end
            m_table[ch] = exp_spd;
            wait_until(s + PERIOD);
            checks++;
            if (rd_speed !== 8'(exp_spd) || speed_valid !== 1'b0 || speed_out !== 8'(exp_spd)) begin
                failures++;
                $display("FAIL rd_new ch=%0d: rd_speed=%0d valid=%b speed=%0d, required %0d 0 %0d",
                         ch, rd_speed, speed_valid, speed_out, exp_spd, exp_spd);
            end
            next_s = s + PERIOD;
        end
    endtask

    // Called right after scan_windows: the next pick has already happened.
    task automatic stop_scan;
        enable = 1'b0;
        m_cur = rr_next(m_cur, m_mask);
        wait_until(cyc + 2);
        checks++;
        if (busy !== 1'b0 || win_active !== 1'b0 || cur_ch !== CHW'(m_cur)) begin
            failures++;
            $display("FAIL stop_idle: busy=%b win=%b cur_ch=%0d, required 0 0 %0d",
                     busy, win_active, cur_ch, m_cur);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (busy !== 1'b0 || win_active !== 1'b0 || speed_valid !== 1'b0 || speed_out !== 8'd0 ||
            speed_ch !== '0 || ovf !== 1'b0 || cur_ch !== CHW'(NCH - 1)) begin
            failures++;
            $display("FAIL %s: busy=%b win=%b valid=%b speed=%0d ch=%0d ovf=%b cur=%0d, required 0 0 0 0 0 0 %0d",
                     tag, busy, win_active, speed_valid, speed_out, speed_ch, ovf, cur_ch, NCH - 1);
        end
        for (int c = 0; c < NCH; c++) begin
            rd_ch = CHW'(c);
            #1;
            checks++;
            if (rd_speed !== 8'd0) begin
                failures++;
                $display("FAIL %s_table ch=%0d: rd_speed=%0d, required 0", tag, c, rd_speed);
            end
        end
        m_cur = NCH - 1;
        for (int c = 0; c < NCH; c++) m_table[c] = 0;
    endtask

    task automatic test_reset;
        for (int c = 0; c < NCH; c++) noise[c] = 1'b1;
        wait_until(20);
        check_reset_values("reset_hold");
        reset = 1'b1;
        enable = 1'b0;
        ch_mask = 4'b1111;
        wait_until(cyc + 20);
        checks++;
        if (busy !== 1'b0 || cur_ch !== CHW'(NCH - 1) || nvalid !== 0) begin
            failures++;
            $display("FAIL idle_disabled: busy=%b cur=%0d nvalid=%0d, required 0 %0d 0", busy, cur_ch, nvalid, NCH - 1);
        end
    endtask

    task automatic test_single_channel;
        set_clock(0, 10, 3);
        scan_windows_start(4'b0001, 3);
    endtask

    task automatic scan_windows_start(input logic [NCH-1:0] mask, input int n);
        start_scan(mask);
        scan_windows(n, 1'b0, '0);
        stop_scan();
    endtask

    task automatic test_round_robin;
        set_clock(0, 10, 5);
        set_clock(1, 20, 7);
        noise[2] = 1'b1;
        set_clock(3, 5, 2);
        start_scan(4'b1011);
        scan_windows(4, 1'b0, '0);
        rd_ch = 2'd2;
        #1;
        checks++;
        if (rd_speed !== 8'd0) begin
            failures++;
            $display("FAIL unscanned_ch2: rd_speed=%0d, required 0", rd_speed);
        end
        // mask the running channel off mid-window: it still publishes, then ch2 follows
        scan_windows(1, 1'b1, 4'b0100);
        scan_windows(1, 1'b0, '0);
        stop_scan();
    endtask

    task automatic test_saturation;
        set_clock(0, 2, 1);
        start_scan(4'b0001);
        scan_windows(1, 1'b0, '0);
        checks++;
        if (speed_out !== 8'd255 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL saturate: speed=%0d ovf=%b, required 255 1", speed_out, ovf);
        end
        set_clock(0, 8, 3);
        scan_windows(1, 1'b0, '0);
        stop_scan();
    endtask

    task automatic test_held_high;
        set_level(1, 1);
        noise[0] = 1'b1;
        wait_until(cyc + 10);
        start_scan(4'b0010);
        scan_windows(1, 1'b0, '0);
        checks++;
        if (speed_out !== 8'd0 || speed_ch !== 2'd1) begin
            failures++;
            $display("FAIL held_high: speed=%0d ch=%0d, required 0 1", speed_out, speed_ch);
        end
        stop_scan();
    endtask

    task automatic test_abort_and_reset;
        int s, ch, nv;
        for (int c = 0; c < NCH; c++) set_clock(c, $urandom_range(2, 16), 1);
        start_scan(4'b1111);
        s = next_s;
        ch = rr_next(m_cur, m_mask);
        wait_until(s + SET + 50);
        rd_ch = CHW'(ch);
        checks++;
        if (win_active !== 1'b1 || cur_ch !== CHW'(ch)) begin
            failures++;
            $display("FAIL abort_pre: win=%b cur=%0d, required 1 %0d", win_active, cur_ch, ch);
        end
        nv = nvalid;
        enable = 1'b0;
        wait_until(s + SET + 51);
        checks++;
        if (busy !== 1'b0 || win_active !== 1'b0 || cur_ch !== CHW'(ch)) begin
            failures++;
            $display("FAIL abort_idle: busy=%b win=%b cur=%0d, required 0 0 %0d", busy, win_active, cur_ch, ch);
        end
        m_cur = ch;
        wait_until(cyc + 20);
        checks++;
        if (nvalid !== nv || rd_speed !== 8'(m_table[ch])) begin
            failures++;
            $display("FAIL abort_nopub: nvalid=%0d rd_speed=%0d, required %0d %0d", nvalid, rd_speed, nv, m_table[ch]);
        end
        start_scan(4'b1111);
        scan_windows(1, 1'b0, '0);
        wait_until(next_s + SET + 30);
        reset = 1'b0;
        #1;
        check_reset_values("reset_mid");
        enable = 1'b0;
        wait_until(cyc + 3);
        reset = 1'b1;
        wait_until(cyc + 3);
    endtask

    task automatic test_random;
        for (int it = 0; it < 3; it++) begin
            logic [NCH-1:0] mask;
            mask = 4'($urandom_range(1, 15));
            for (int c = 0; c < NCH; c++) begin
                int mode, p;
                mode = $urandom_range(0, 2);
                p = $urandom_range(2, 24);
                if (mode == 0) set_clock(c, p, $urandom_range(1, p - 1));
                else if (mode == 1) noise[c] = 1'b1;
                else set_level(c, $urandom_range(0, 1));
            end
            start_scan(mask);
            scan_windows(3, 1'b0, '0);
            stop_scan();
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_saturation();
        test_held_high();
        test_abort_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
